// File: rtl/card_pkg.sv
// Card rank type, deck limits and baccarat scoring helpers.
// Shared by the datapath and the dealing FSM (pcard3 decoding).
package card_pkg;

  typedef logic [3:0] rank_t;

  localparam rank_t NUM_RANKS = 4'd13;
  localparam rank_t FACE_MIN  = 4'd10;

  // Empty slots (rank 0) and 10/J/Q/K all count as zero.
  function automatic logic [3:0] card_value(input rank_t r);
    if (r == 4'd0 || r >= FACE_MIN) begin
      return 4'd0;
    end
    return r;
  endfunction

  // Sum of three values is at most 27, so two conditional subtractions replace mod 10.
  function automatic logic [3:0] hand_score(input rank_t c1, input rank_t c2, input rank_t c3);
    logic [4:0] sum;
    sum = {1'b0, card_value(c1)} + {1'b0, card_value(c2)} + {1'b0, card_value(c3)};
    if (sum >= 5'd20) begin
      sum = sum - 5'd20;
    end else if (sum >= 5'd10) begin
      sum = sum - 5'd10;
    end
    return sum[3:0];
  endfunction

endpackage

// File: rtl/dealcard.sv
// Free-running dealer: counts 1..NUM_RANKS and wraps, one step per slow_clock edge.
// Output is the registered current rank; no backpressure, never pauses.
module dealcard
  import card_pkg::*;
(
  input  logic  slow_clock,
  input  logic  resetb,
  output rank_t deal
);

  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      deal <= 4'd1;
    end else if (deal >= NUM_RANKS) begin
      deal <= 4'd1;
    end else begin
      deal <= deal + 4'd1;
    end
  end

endmodule

// File: rtl/card_datapath.sv
// Baccarat datapath: six card slots loaded from the dealer, plus player/dealer scores.
// Slots update one edge after a load strobe; scores follow combinationally; no backpressure.
module card_datapath
  import card_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore
);

  rank_t deal;

  dealcard u_dealcard (
    .slow_clock (slow_clock),
    .resetb     (resetb),
    .deal       (deal)
  );

  // Slots are independent; simultaneous loads all capture the same pre-increment rank.
  always_ff @(posedge slow_clock) begin
    if (resetb) begin
      pcard1 <= 4'd0;
      pcard2 <= 4'd0;
      pcard3 <= 4'd0;
      dcard1 <= 4'd0;
      dcard2 <= 4'd0;
      dcard3 <= 4'd0;
    end else begin
      if (load_pcard1) pcard1 <= deal;
      if (load_pcard2) pcard2 <= deal;
      if (load_pcard3) pcard3 <= deal;
      if (load_dcard1) dcard1 <= deal;
      if (load_dcard2) dcard2 <= deal;
      if (load_dcard3) dcard3 <= deal;
    end
  end

  always_comb begin
    pscore = hand_score(pcard1, pcard2, pcard3);
    dscore = hand_score(dcard1, dcard2, dcard3);
  end

endmodule

// File: tb/tb_card_datapath.sv
// Directed bench for card_datapath: hand-computed ranks and scores per scenario.
module tb_card_datapath;

  logic       slow_clock;
  logic       resetb;
  logic       load_pcard1, load_pcard2, load_pcard3;
  logic       load_dcard1, load_dcard2, load_dcard3;
  logic [3:0] pcard1, pcard2, pcard3, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore;

  int errors = 0;
  int checks = 0;

  card_datapath dut (
    .slow_clock  (slow_clock),
    .resetb      (resetb),
    .load_pcard1 (load_pcard1),
    .load_pcard2 (load_pcard2),
    .load_pcard3 (load_pcard3),
    .load_dcard1 (load_dcard1),
    .load_dcard2 (load_dcard2),
    .load_dcard3 (load_dcard3),
    .pcard1      (pcard1),
    .pcard2      (pcard2),
    .pcard3      (pcard3),
    .dcard1      (dcard1),
    .dcard2      (dcard2),
    .dcard3      (dcard3),
    .pscore      (pscore),
    .dscore      (dscore)
  );

  initial slow_clock = 1'b0;
  always #5 slow_clock = ~slow_clock;

  // mask bits: {pc1, pc2, pc3, dc1, dc2, dc3}
  task automatic set_loads(input logic [5:0] m);
    {load_pcard1, load_pcard2, load_pcard3, load_dcard1, load_dcard2, load_dcard3} = m;
  endtask

  // After this returns, the next rising edge is edge 1 after release (deal = 1).
  task automatic do_reset();
    resetb = 1'b1;
    set_loads(6'b0);
    repeat (2) @(posedge slow_clock);
    #1;
    resetb = 1'b0;
  endtask

  task automatic step(input logic [5:0] m);
    set_loads(m);
    @(posedge slow_clock);
    #1;
    set_loads(6'b0);
  endtask

  task automatic skip(input int n);
    repeat (n) @(posedge slow_clock);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pcard1 !== 4'd0) begin errors++; $display("FAIL rst_pcard1 got=%0d exp=0", pcard1); end
    checks++; if (pcard2 !== 4'd0) begin errors++; $display("FAIL rst_pcard2 got=%0d exp=0", pcard2); end
    checks++; if (pcard3 !== 4'd0) begin errors++; $display("FAIL rst_pcard3 got=%0d exp=0", pcard3); end
    checks++; if (dcard1 !== 4'd0) begin errors++; $display("FAIL rst_dcard1 got=%0d exp=0", dcard1); end
    checks++; if (dcard2 !== 4'd0) begin errors++; $display("FAIL rst_dcard2 got=%0d exp=0", dcard2); end
    checks++; if (dcard3 !== 4'd0) begin errors++; $display("FAIL rst_dcard3 got=%0d exp=0", dcard3); end
    checks++; if (pscore !== 4'd0) begin errors++; $display("FAIL rst_pscore got=%0d exp=0", pscore); end
    checks++; if (dscore !== 4'd0) begin errors++; $display("FAIL rst_dscore got=%0d exp=0", dscore); end
  endtask

  task automatic test_basic_load();
    do_reset();
    step(6'b100000);                       // edge 1, deal=1
    checks++; if (pcard1 !== 4'd1) begin errors++; $display("FAIL basic_pcard1 got=%0d exp=1", pcard1); end
    checks++; if (pscore !== 4'd1) begin errors++; $display("FAIL basic_pscore1 got=%0d exp=1", pscore); end
    skip(7);                               // edges 2..8
    step(6'b010000);                       // edge 9, deal=9
    checks++; if (pcard2 !== 4'd9) begin errors++; $display("FAIL basic_pcard2 got=%0d exp=9", pcard2); end
    checks++; if (pscore !== 4'd0) begin errors++; $display("FAIL basic_pscore2 got=%0d exp=0", pscore); end
  endtask

  task automatic test_face_cards();
    do_reset();
    skip(11);                              // edges 1..11
    step(6'b000100);                       // edge 12, deal=12
    step(6'b000010);                       // edge 13, deal=13
    checks++; if (dcard1 !== 4'd12) begin errors++; $display("FAIL face_dcard1 got=%0d exp=12", dcard1); end
    checks++; if (dcard2 !== 4'd13) begin errors++; $display("FAIL face_dcard2 got=%0d exp=13", dcard2); end
    checks++; if (dscore !== 4'd0) begin errors++; $display("FAIL face_dscore got=%0d exp=0", dscore); end
    skip(6);                               // edges 14..19 (deal 1..6)
    step(6'b000001);                       // edge 20, deal=7
    checks++; if (dcard3 !== 4'd7) begin errors++; $display("FAIL face_dcard3 got=%0d exp=7", dcard3); end
    checks++; if (dscore !== 4'd7) begin errors++; $display("FAIL face_dscore3 got=%0d exp=7", dscore); end
  endtask

  task automatic test_wrap();
    do_reset();
    skip(13);                              // edges 1..13
    step(6'b001000);                       // edge 14, deal wrapped to 1
    checks++; if (pcard3 !== 4'd1) begin errors++; $display("FAIL wrap_first got=%0d exp=1", pcard3); end
    skip(11);                              // edges 15..25
    step(6'b001000);                       // edge 26, deal=13
    checks++; if (pcard3 !== 4'd13) begin errors++; $display("FAIL wrap_max got=%0d exp=13", pcard3); end
    step(6'b001000);                       // edge 27, deal=1
    checks++; if (pcard3 !== 4'd1) begin errors++; $display("FAIL wrap_after got=%0d exp=1", pcard3); end
  endtask

  task automatic test_max_sum();
    do_reset();
    skip(8);
    step(6'b111000);                       // edge 9, all three = 9
    checks++; if (pscore !== 4'd7) begin errors++; $display("FAIL max_pscore got=%0d exp=7", pscore); end
    checks++; if (pcard3 !== 4'd9) begin errors++; $display("FAIL max_pcard3 got=%0d exp=9", pcard3); end
    do_reset();
    skip(2);
    step(6'b010000);                       // edge 3 -> pcard2=3
    skip(4);
    step(6'b100000);                       // edge 8 -> pcard1=8
    checks++; if (pcard3 !== 4'd0) begin errors++; $display("FAIL empty_pcard3 got=%0d exp=0", pcard3); end
    checks++; if (pscore !== 4'd1) begin errors++; $display("FAIL empty_pscore got=%0d exp=1", pscore); end
  endtask

  task automatic test_simultaneous();
    do_reset();
    skip(4);
    step(6'b100100);                       // edge 5
    checks++; if (pcard1 !== 4'd5) begin errors++; $display("FAIL sim_pcard1 got=%0d exp=5", pcard1); end
    checks++; if (dcard1 !== 4'd5) begin errors++; $display("FAIL sim_dcard1 got=%0d exp=5", dcard1); end
    checks++; if (pscore !== 4'd5) begin errors++; $display("FAIL sim_pscore got=%0d exp=5", pscore); end
    checks++; if (dscore !== 4'd5) begin errors++; $display("FAIL sim_dscore got=%0d exp=5", dscore); end
    step(6'b100000);                       // edge 6, reload
    checks++; if (pcard1 !== 4'd6) begin errors++; $display("FAIL reload_pcard1 got=%0d exp=6", pcard1); end
    checks++; if (pscore !== 4'd6) begin errors++; $display("FAIL reload_pscore got=%0d exp=6", pscore); end
    checks++; if (dcard1 !== 4'd5) begin errors++; $display("FAIL reload_dcard1 got=%0d exp=5", dcard1); end
  endtask

  task automatic test_reset_mid_hand();
    do_reset();
    step(6'b100000);                       // pcard1=1
    step(6'b010000);                       // pcard2=2
    step(6'b000100);                       // dcard1=3
    step(6'b000010);                       // dcard2=4
    checks++; if (pscore !== 4'd3) begin errors++; $display("FAIL mid_pscore got=%0d exp=3", pscore); end
    checks++; if (dscore !== 4'd7) begin errors++; $display("FAIL mid_dscore got=%0d exp=7", dscore); end
    resetb = 1'b1;
    set_loads(6'b000001);
    @(posedge slow_clock);
    #1;
    set_loads(6'b0);
    resetb = 1'b0;
    checks++; if (pcard1 !== 4'd0) begin errors++; $display("FAIL mid_rst_pcard1 got=%0d exp=0", pcard1); end
    checks++; if (pcard2 !== 4'd0) begin errors++; $display("FAIL mid_rst_pcard2 got=%0d exp=0", pcard2); end
    checks++; if (dcard1 !== 4'd0) begin errors++; $display("FAIL mid_rst_dcard1 got=%0d exp=0", dcard1); end
    checks++; if (dcard2 !== 4'd0) begin errors++; $display("FAIL mid_rst_dcard2 got=%0d exp=0", dcard2); end
    checks++; if (dcard3 !== 4'd0) begin errors++; $display("FAIL mid_rst_dcard3 got=%0d exp=0", dcard3); end
    checks++; if (pscore !== 4'd0) begin errors++; $display("FAIL mid_rst_pscore got=%0d exp=0", pscore); end
    checks++; if (dscore !== 4'd0) begin errors++; $display("FAIL mid_rst_dscore got=%0d exp=0", dscore); end
    step(6'b000001);                       // first edge after release, deal=1
    checks++; if (dcard3 !== 4'd1) begin errors++; $display("FAIL mid_restart got=%0d exp=1", dcard3); end
    checks++; if (dscore !== 4'd1) begin errors++; $display("FAIL mid_restart_dscore got=%0d exp=1", dscore); end
  endtask

  initial begin
    resetb = 1'b1;
    set_loads(6'b0);
    test_reset();
    test_basic_load();
    test_face_cards();
    test_wrap();
    test_max_sum();
    test_simultaneous();
    test_reset_mid_hand();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
